agree_predictor: RTL and testbench

Front-end agree branch predictor for the 5-stage RV32I pipeline. IF looks up the block with the fetch PC and gets a predicted next PC. EX returns the resolved outcome of each conditional branch; that outcome is the taken decision the pipeline derives from the branch comparator's less/equal flags and funct3. The block trains its tables from that outcome and flags mispredicts for the flush/redirect logic.

---
 rtl/agree_predictor_if.sv | 37 +++
 rtl/agree_predictor.sv | 122 ++++++++++++
 tb/tb_agree_predictor.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/agree_predictor_if.sv
// Fetch-lookup and EX-resolve signal bundle for the agree branch predictor.
// slave = predictor side, master = pipeline side.
interface agree_predictor_if #(
    parameter int PHT_IDX_W = 8
);
    logic [31:0]          i_if_pc;
    logic                 o_pred_taken;
    logic [31:0]          o_pred_next_pc;
    logic [PHT_IDX_W-1:0] o_pred_idx;

    logic                 i_ex_br_valid;
    logic [31:0]          i_ex_pc;
    logic [PHT_IDX_W-1:0] i_ex_idx;
    logic                 i_ex_taken;
    logic [31:0]          i_ex_target;
    logic                 i_ex_pred_taken;
    logic [31:0]          i_ex_pred_next_pc;

    logic                 o_mispredict;
    logic [31:0]          o_redirect_pc;
    logic [31:0]          o_br_cnt;
    logic [31:0]          o_mis_cnt;

    modport slave (
        input  i_if_pc, i_ex_br_valid, i_ex_pc, i_ex_idx, i_ex_taken,
               i_ex_target, i_ex_pred_taken, i_ex_pred_next_pc,
        output o_pred_taken, o_pred_next_pc, o_pred_idx,
               o_mispredict, o_redirect_pc, o_br_cnt, o_mis_cnt
    );

    modport master (
        output i_if_pc, i_ex_br_valid, i_ex_pc, i_ex_idx, i_ex_taken,
               i_ex_target, i_ex_pred_taken, i_ex_pred_next_pc,
        input  o_pred_taken, o_pred_next_pc, o_pred_idx,
               o_mispredict, o_redirect_pc, o_br_cnt, o_mis_cnt
    );
endinterface

// File: rtl/agree_predictor.sv
// Agree branch predictor: direct-mapped BTB holding a per-branch bias, plus a
// gshare-indexed PHT whose counters say whether to agree with that bias.
module agree_predictor #(
    parameter int PHT_IDX_W = 8,
    parameter int BTB_IDX_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    agree_predictor_if.slave      bus
);
    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;

    logic                 r_btb_valid  [BTB_N];
    logic [TAG_W-1:0]     r_btb_tag    [BTB_N];
    logic [31:0]          r_btb_target [BTB_N];
    logic                 r_btb_bias   [BTB_N];
    logic [1:0]           r_pht        [PHT_N];
    logic [PHT_IDX_W-1:0] r_ghr;
    logic [31:0]          r_br_cnt;
    logic [31:0]          r_mis_cnt;

    logic [BTB_IDX_W-1:0] w_if_bi;
    logic                 w_if_hit;
    logic [PHT_IDX_W-1:0] w_pred_idx;
    logic                 w_pred_taken;
    logic [31:0]          w_pred_next_pc;

    logic [BTB_IDX_W-1:0] w_ex_bi;
    logic                 w_ex_hit;
    logic                 w_eff_bias;
    logic [31:0]          w_actual_next;
    logic                 w_mispredict;
    logic [1:0]           w_pht_cur;
    logic [1:0]           w_pht_nxt;
    logic                 w_unused;

    // Fetch-side lookup; reads only registered state, so same-cycle updates are not visible.
    always_comb begin
        w_if_bi      = bus.i_if_pc[BTB_IDX_W+1:2];
        w_if_hit     = r_btb_valid[w_if_bi] &&
                       (r_btb_tag[w_if_bi] == bus.i_if_pc[31:BTB_IDX_W+2]);
        w_pred_idx   = bus.i_if_pc[PHT_IDX_W+1:2] ^ r_ghr;
        w_pred_taken = w_if_hit & (r_btb_bias[w_if_bi] ~^ r_pht[w_pred_idx][1]);
        if (w_pred_taken) begin
            w_pred_next_pc = r_btb_target[w_if_bi];
        end else begin
            w_pred_next_pc = bus.i_if_pc + 32'd4;
        end
    end

    // EX-side resolve: comparing next PCs also catches a stale BTB target.
    always_comb begin
        w_ex_bi  = bus.i_ex_pc[BTB_IDX_W+1:2];
        w_ex_hit = r_btb_valid[w_ex_bi] &&
                   (r_btb_tag[w_ex_bi] == bus.i_ex_pc[31:BTB_IDX_W+2]);
        if (w_ex_hit) begin
            w_eff_bias = r_btb_bias[w_ex_bi];
        end else begin
            w_eff_bias = bus.i_ex_taken;
        end
        if (bus.i_ex_taken) begin
            w_actual_next = bus.i_ex_target;
        end else begin
            w_actual_next = bus.i_ex_pc + 32'd4;
        end
        w_mispredict = bus.i_ex_br_valid & (w_actual_next != bus.i_ex_pred_next_pc);
    end

    // Saturating agree-counter step for the PHT entry carried from fetch.
    always_comb begin
        w_pht_cur = r_pht[bus.i_ex_idx];
        if (bus.i_ex_taken == w_eff_bias) begin
            w_pht_nxt = (w_pht_cur == 2'd3) ? 2'd3 : w_pht_cur + 2'd1;
        end else begin
            w_pht_nxt = (w_pht_cur == 2'd0) ? 2'd0 : w_pht_cur - 2'd1;
        end
    end

    // Table, history and counter state; a write pending under reset is dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= 32'd0;
                r_btb_bias[i]   <= 1'b0;
            end
            for (int i = 0; i < PHT_N; i++) begin
                r_pht[i] <= 2'b10;
            end
            r_ghr     <= '0;
            r_br_cnt  <= 32'd0;
            r_mis_cnt <= 32'd0;
        end else if (bus.i_ex_br_valid) begin
            if (!w_ex_hit) begin
                r_btb_valid[w_ex_bi] <= 1'b1;
                r_btb_tag[w_ex_bi]   <= bus.i_ex_pc[31:BTB_IDX_W+2];
                r_btb_bias[w_ex_bi]  <= bus.i_ex_taken;
            end
            r_btb_target[w_ex_bi] <= bus.i_ex_target;
            r_pht[bus.i_ex_idx]   <= w_pht_nxt;
            r_ghr                 <= {r_ghr[PHT_IDX_W-2:0], bus.i_ex_taken};
            r_br_cnt              <= r_br_cnt + 32'd1;
            if (w_mispredict) begin
                r_mis_cnt <= r_mis_cnt + 32'd1;
            end
        end
    end

    // The carried prediction bit is redundant with the carried next PC.
    assign w_unused = bus.i_ex_pred_taken;

    assign bus.o_pred_taken   = w_pred_taken;
    assign bus.o_pred_next_pc = w_pred_next_pc;
    assign bus.o_pred_idx     = w_pred_idx;
    assign bus.o_mispredict   = w_mispredict;
    assign bus.o_redirect_pc  = w_actual_next;
    assign bus.o_br_cnt       = r_br_cnt;
    assign bus.o_mis_cnt      = r_mis_cnt;
endmodule

// File: tb/tb_agree_predictor.sv
// Directed bench for agree_predictor: per-cycle comparison against an
// array-based behavioural model, plus hand-computed literal expectations.
module tb_agree_predictor;
    localparam int PW    = 8;
    localparam int BW    = 6;
    localparam int PHT_N = 256;
    localparam int BTB_N = 64;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;

    agree_predictor_if #(.PHT_IDX_W(PW)) bus();

    agree_predictor #(.PHT_IDX_W(PW), .BTB_IDX_W(BW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    bit          m_valid  [BTB_N];
    logic [31:0] m_tag    [BTB_N];
    logic [31:0] m_target [BTB_N];
    bit          m_bias   [BTB_N];
    int          m_pht    [PHT_N];
    int          m_ghr;
    logic [31:0] m_br;
    logic [31:0] m_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BTB_N; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < PHT_N; i++) m_pht[i] = 2;
        m_ghr = 0;
        m_br  = 32'd0;
        m_mis = 32'd0;
    endtask

    function automatic int m_bi(input logic [31:0] pc);
        return int'((pc >> 2) % BTB_N);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_bi(pc)] && (m_tag[m_bi(pc)] == (pc >> (BW + 2)));
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % PHT_N) ^ m_ghr;
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_bias[m_bi(pc)] == (m_pht[m_idx(pc)] >= 2));
    endfunction

    function automatic logic [31:0] m_pred_next(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_target[m_bi(pc)] : pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_actual_next();
        return bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
    endfunction

    task automatic model_update();
        int bi;
        int ix;
        bit eff;
        bi = m_bi(bus.i_ex_pc);
        ix = int'(bus.i_ex_idx);
        if (m_actual_next() != bus.i_ex_pred_next_pc) m_mis = m_mis + 32'd1;
        m_br = m_br + 32'd1;
        eff = m_hit(bus.i_ex_pc) ? m_bias[bi] : bus.i_ex_taken;
        if (!m_hit(bus.i_ex_pc)) begin
            m_valid[bi] = 1'b1;
            m_tag[bi]   = bus.i_ex_pc >> (BW + 2);
            m_bias[bi]  = bus.i_ex_taken;
        end
        m_target[bi] = bus.i_ex_target;
        if (bus.i_ex_taken == eff) begin
            if (m_pht[ix] < 3) m_pht[ix]++;
        end else begin
            if (m_pht[ix] > 0) m_pht[ix]--;
        end
        m_ghr = ((m_ghr << 1) | int'(bus.i_ex_taken)) % PHT_N;
    endtask

    // Model check of every output, away from the active edge
    always @(negedge i_clk) begin : cmp
        bit em;
        em = bus.i_ex_br_valid && (m_actual_next() != bus.i_ex_pred_next_pc);
        chk("pred_taken", bus.o_pred_taken, m_pred_taken(bus.i_if_pc));
        chk("pred_next_pc", bus.o_pred_next_pc, m_pred_next(bus.i_if_pc));
        chk("pred_idx", bus.o_pred_idx, m_idx(bus.i_if_pc));
        chk("mispredict", bus.o_mispredict, em);
        if (em) chk("redirect_pc", bus.o_redirect_pc, m_actual_next());
        chk("br_cnt", bus.o_br_cnt, m_br);
        chk("mis_cnt", bus.o_mis_cnt, m_mis);
    end

    task automatic cyc();
        @(posedge i_clk);
        if (i_rst_n && bus.i_ex_br_valid) model_update();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [7:0] idx,
                          input logic t, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] pn);
        bus.i_ex_br_valid     = v;
        bus.i_ex_pc           = pc;
        bus.i_ex_idx          = idx;
        bus.i_ex_taken        = t;
        bus.i_ex_target       = tgt;
        bus.i_ex_pred_taken   = pt;
        bus.i_ex_pred_next_pc = pn;
    endtask

    localparam logic [31:0] VPC [10] = '{32'h140, 32'h240, 32'h140, 32'h1C, 32'h1C,
                                         32'h1C, 32'hFFFF_FFFC, 32'h1C, 32'h240, 32'h140};
    localparam logic [31:0] VTG [10] = '{32'h500, 32'h600, 32'h540, 32'h10, 32'h10,
                                         32'h10, 32'h8, 32'h20, 32'h600, 32'h500};
    localparam logic        VTK [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                         1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        model_reset();
        bus.i_if_pc = 32'h100;
        set_ex(1'b0, 32'h0, 8'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("rst_pred_taken", bus.o_pred_taken, 32'd0);
        chk("rst_pred_next", bus.o_pred_next_pc, 32'h104);
        chk("rst_pred_idx", bus.o_pred_idx, 32'h40);
        chk("rst_br_cnt", bus.o_br_cnt, 32'd0);
        chk("rst_mis_cnt", bus.o_mis_cnt, 32'd0);
        chk("rst_mispredict", bus.o_mispredict, 32'd0);
        bus.i_if_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap_pred_next", bus.o_pred_next_pc, 32'h0);
        bus.i_if_pc = 32'h100;
        repeat (2) cyc();
        i_rst_n = 1'b1;

        // Allocate taken branch at 0x100; same-cycle lookup sees old contents.
        set_ex(1'b1, 32'h100, 8'h40, 1'b1, 32'h80, 1'b0, 32'h104);
        #1;
        chk("alloc_mispredict", bus.o_mispredict, 32'd1);
        chk("alloc_redirect", bus.o_redirect_pc, 32'h80);
        chk("collide_old_taken", bus.o_pred_taken, 32'd0);
        cyc();
        bus.i_ex_br_valid = 1'b0;
        #1;
        chk("alloc_pred_taken", bus.o_pred_taken, 32'd1);
        chk("alloc_pred_next", bus.o_pred_next_pc, 32'h80);
        chk("alloc_ghr_idx", bus.o_pred_idx, 32'h41);
        chk("alloc_mis_cnt", bus.o_mis_cnt, 32'd1);

        // Three not-taken resolves at idx 0x41: counter 2->1->0->0.
        for (int k = 0; k < 3; k++) begin
            set_ex(1'b1, 32'h100, 8'h41, 1'b0, 32'h80, 1'b1, 32'h80);
            cyc();
        end
        // Walk history back to GHR=1 without touching idx 0x41.
        for (int k = 0; k < 8; k++) begin
            set_ex(1'b1, 32'h100, 8'hF0, (k == 7), 32'h80, 1'b0, 32'h104);
            cyc();
        end
        bus.i_ex_br_valid = 1'b0;
        #1;
        chk("train_idx", bus.o_pred_idx, 32'h41);
        chk("train_pred_taken", bus.o_pred_taken, 32'd0);
        chk("train_pred_next", bus.o_pred_next_pc, 32'h104);
        chk("train_br_cnt", bus.o_br_cnt, 32'd12);
        chk("train_mis_cnt", bus.o_mis_cnt, 32'd5);

        // 0x200 aliases 0x100's entry and allocates with bias 0.
        set_ex(1'b1, 32'h200, 8'h80, 1'b0, 32'h300, 1'b0, 32'h204);
        #1;
        chk("nt_mispredict", bus.o_mispredict, 32'd0);
        cyc();
        bus.i_ex_br_valid = 1'b0;
        #1;
        chk("alias_pred_taken", bus.o_pred_taken, 32'd0);
        chk("alias_pred_next", bus.o_pred_next_pc, 32'h104);
        bus.i_if_pc = 32'h200;
        #1;
        chk("nt_pred_idx", bus.o_pred_idx, 32'h82);
        chk("nt_pred_taken", bus.o_pred_taken, 32'd0);
        chk("nt_pred_next", bus.o_pred_next_pc, 32'h204);

        // Reset asserted with an update pending discards it.
        set_ex(1'b1, 32'h140, 8'h10, 1'b1, 32'h500, 1'b0, 32'h144);
        bus.i_if_pc = 32'h140;
        #1;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_br_cnt", bus.o_br_cnt, 32'd0);
        chk("arst_mis_cnt", bus.o_mis_cnt, 32'd0);
        cyc();
        bus.i_ex_br_valid = 1'b0;
        cyc();
        i_rst_n = 1'b1;
        #1;
        chk("arst_pred_taken", bus.o_pred_taken, 32'd0);
        chk("arst_pred_next", bus.o_pred_next_pc, 32'h144);
        chk("arst_pred_idx", bus.o_pred_idx, 32'h50);

        // Mixed traffic with pipeline-carried fields taken from the model.
        for (int k = 0; k < 10; k++) begin
            bus.i_if_pc = VPC[(k + 3) % 10];
            set_ex(1'b1, VPC[k], 8'(m_idx(VPC[k])), VTK[k], VTG[k],
                   m_pred_taken(VPC[k]), m_pred_next(VPC[k]));
            cyc();
            bus.i_ex_br_valid = 1'b0;
            bus.i_if_pc = VPC[k];
            cyc();
        end
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
